pixel_window_ctrl: RTL and testbench
====================================

// Module: pixel_window_ctrl
// PURPOSE
//   Sequencer for the 4x4 pixel matrix feeding the 3x3 convolution datapath.
//   - Accepts one 4x4 block from the line buffer and pulses load_enable so the matrix captures it.
//   - Steps select through the four 3x3 windows (1..4), one per downstream accept.
//   - Counts blocks per frame and flags frame completion.
// PARAMETERS
//   BLOCKS_PER_FRAME  16  number of 4x4 blocks in one frame (>=1)
//   CNT_W             16  width of block counter; must hold BLOCKS_PER_FRAME-1
// PORTS
//   clk          in   1      system clock, all logic on rising edge
//   rst          in   1      synchronous, active-high reset
//   block_valid  in   1      line buffer presents a complete 4x4 block
//   conv_ready   in   1      convolution datapath accepts the current window
//   flush        in   1      abort current block/frame, synchronous
//   block_ack    out  1      1-cycle pulse: block consumed, buffer may advance
//   load_enable  out  1      to pixel matrix: capture buffer_pixels this cycle
//   select       out  3      to pixel matrix: 0=none, 1..4 = window TL,TR,BL,BR
//   conv_valid   out  1      window on conv_pixels is valid for the datapath
//   block_done   out  1      1-cycle pulse: 4th window of a block accepted
//   frame_done   out  1      1-cycle pulse: last block of frame completed
//   block_cnt    out  CNT_W  index of block currently being processed
// BEHAVIOUR
//   Reset: one clock with rst=1 forces state=IDLE; all outputs 0, block_cnt=0.
//     rst overrides flush and every other input.
//   All outputs are decoded from registered state (Moore); no input-to-output combinational path.
//   States:
//     IDLE: load_enable=0, select=0, conv_valid=0.
//       block_valid=1 -> LOAD.
//     LOAD (exactly 1 cycle): load_enable=1, block_ack=1, select=0.
//       -> WIN, with win=1.
//     WIN: select=win (1..4), conv_valid=1.
//       conv_ready=0 -> hold select/conv_valid unchanged (stall, no timeout).
//       conv_ready=1 and win<4 -> win+1.
//       conv_ready=1 and win=4 -> block complete.
//   Block complete (same edge as the final accept; pulses seen the next cycle):
//     block_done=1.
//     If block_cnt=BLOCKS_PER_FRAME-1: frame_done=1 and block_cnt wraps to 0; else block_cnt+1.
//     Next state: LOAD if block_valid=1 (back-to-back, no IDLE bubble), else IDLE.
//   Latency: block_valid high at edge k -> load_enable during cycle k+1 -> select=1,
//     conv_valid=1 from cycle k+2. Minimum block period = 5 cycles (1 LOAD + 4 WIN).
//   Handshake: a window transfers only when conv_valid&&conv_ready on a clock edge.
//     select never changes while conv_valid=1 and conv_ready=0.
//   block_valid is ignored outside IDLE and outside the block-complete edge.
//     A block is never acked twice: block_ack occurs only in LOAD.
//   flush=1 (in any state): next state IDLE, win cleared, block_cnt=0, no done pulses.
//     If flush coincides with the final accept, flush wins: no block_done or frame_done.
//   BLOCKS_PER_FRAME=1: every block_done is accompanied by frame_done; block_cnt stays 0.
//   select values 5..7 are never driven.
// TESTING
//   1. Reset, then block_valid=1 held, conv_ready=1 held:
//      load_enable one cycle, then select 1,2,3,4 on consecutive cycles, block_ack once per block,
//      blocks every 5 cycles.
//   2. Single block with conv_ready low 3 cycles during select=2:
//      select holds at 2, conv_valid=1 throughout; completes after 4 accepts.
//   3. BLOCKS_PER_FRAME=4, 4 blocks:
//      block_cnt 0,1,2,3; frame_done pulses once with the 4th block_done; block_cnt returns to 0.
//   4. flush asserted at select=3: next cycle IDLE, all outputs 0, block_cnt=0, no block_done.
//      Next block_valid starts cleanly at LOAD.
//   5. rst asserted mid-WIN (select=2) together with conv_ready=1 and flush=1:
//      next cycle all outputs 0, state IDLE.
//   6. block_valid low after block 1: FSM idles with select=0.
//      block_valid raised 10 cycles later: LOAD on the following cycle.

Source files
------------

// File: rtl/pixel_window_ctrl.sv
// Sequencer for the 4x4 pixel matrix: loads one block, then steps the four 3x3
// windows through the convolution handshake, counting blocks per frame.
module pixel_window_ctrl #(
    parameter int unsigned BLOCKS_PER_FRAME = 16,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             block_valid,
    input  logic             conv_ready,
    input  logic             flush,
    output logic             block_ack,
    output logic             load_enable,
    output logic [2:0]       select,
    output logic             conv_valid,
    output logic             block_done,
    output logic             frame_done,
    output logic [CNT_W-1:0] block_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WIN
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(BLOCKS_PER_FRAME - 1);

    state_t           state_q, state_d;
    logic [2:0]       win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             block_done_q, block_done_d;
    logic             frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        block_done_d = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (block_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WIN;
                win_d   = 3'd1;
            end
            S_WIN: begin
                if (conv_ready) begin
                    if (win_q == 3'd4) begin
                        // final accept: block complete, chain straight into the next load
                        block_done_d = 1'b1;
                        win_d        = '0;
                        state_d      = block_valid ? S_LOAD : S_IDLE;
                        if (cnt_q == LAST_BLK) begin
                            cnt_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        win_d = win_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                win_d   = '0;
            end
        endcase

        // flush takes priority over a coincident final accept
        if (flush) begin
            state_d      = S_IDLE;
            win_d        = '0;
            cnt_d        = '0;
            block_done_d = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            win_q        <= '0;
            cnt_q        <= '0;
            block_done_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            block_done_q <= block_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_enable = (state_q == S_LOAD);
    assign block_ack   = (state_q == S_LOAD);
    assign conv_valid  = (state_q == S_WIN);
    assign select      = (state_q == S_WIN) ? win_q : 3'd0;
    assign block_done  = block_done_q;
    assign frame_done  = frame_done_q;
    assign block_cnt   = cnt_q;

endmodule

// File: tb/tb_pixel_window_ctrl.sv
// Directed table-driven bench for pixel_window_ctrl: a 4-block-per-frame instance
// and a 1-block-per-frame instance driven from the same stimulus.
module tb_pixel_window_ctrl;

    logic        clk = 1'b0;
    logic        rst, block_valid, conv_ready, flush;
    logic        ack0, le0, cv0, bd0, fd0;
    logic [2:0]  sel0;
    logic [15:0] cnt0;
    logic        ack1, le1, cv1, bd1, fd1;
    logic [2:0]  sel1;
    logic [15:0] cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pixel_window_ctrl #(.BLOCKS_PER_FRAME(4), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .block_valid(block_valid), .conv_ready(conv_ready),
        .flush(flush), .block_ack(ack0), .load_enable(le0), .select(sel0),
        .conv_valid(cv0), .block_done(bd0), .frame_done(fd0), .block_cnt(cnt0)
    );

    pixel_window_ctrl #(.BLOCKS_PER_FRAME(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .block_valid(block_valid), .conv_ready(conv_ready),
        .flush(flush), .block_ack(ack1), .load_enable(le1), .select(sel1),
        .conv_valid(cv1), .block_done(bd1), .frame_done(fd1), .block_cnt(cnt1)
    );

    typedef struct {
        logic        rst, bv, cr, fl;
        logic        ack, le;
        logic [2:0]  sel;
        logic        cv, bd, fd;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic bv, input logic cr, input logic fl,
                       input logic ack, input logic le, input logic [2:0] sel,
                       input logic cv, input logic bd, input logic fd, input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.bv = bv; v.cr = cr; v.fl = fl;
        v.ack = ack; v.le = le; v.sel = sel; v.cv = cv;
        v.bd = bd; v.fd = fd; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic bv, input logic cr, input logic fl);
        rst = r; block_valid = bv; conv_ready = cr; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acks[$];
        rst = 1'b1; block_valid = 1'b0; conv_ready = 1'b0; flush = 1'b0;

        // reset
        add(1,0,0,0, 0,0,3'd0,0,0,0,16'd0);
        // a full frame of 4 blocks back-to-back with conv_ready held high
        for (int b = 0; b < 4; b++) begin
            add(0,1,1,0, 1,1,3'd0,0,(b != 0),0,16'(b));
            for (int w = 1; w <= 4; w++) add(0,1,1,0, 0,0,3'(w),1,0,0,16'(b));
        end
        add(0,0,1,0, 0,0,3'd0,0,1,1,16'd0);
        add(0,0,0,0, 0,0,3'd0,0,0,0,16'd0);
        // stall three cycles at window 2; block_valid ignored meanwhile
        add(0,1,0,0, 1,1,3'd0,0,0,0,16'd0);
        add(0,0,1,0, 0,0,3'd1,1,0,0,16'd0);
        add(0,0,1,0, 0,0,3'd2,1,0,0,16'd0);
        for (int i = 0; i < 3; i++) add(0,1,0,0, 0,0,3'd2,1,0,0,16'd0);
        add(0,0,1,0, 0,0,3'd3,1,0,0,16'd0);
        add(0,0,1,0, 0,0,3'd4,1,0,0,16'd0);
        add(0,0,1,0, 0,0,3'd0,0,1,0,16'd1);
        // flush at window 3
        add(0,1,0,0, 1,1,3'd0,0,0,0,16'd1);
        for (int w = 1; w <= 3; w++) add(0,0,1,0, 0,0,3'(w),1,0,0,16'd1);
        add(0,1,1,1, 0,0,3'd0,0,0,0,16'd0);
        add(0,1,0,0, 1,1,3'd0,0,0,0,16'd0);
        for (int w = 1; w <= 4; w++) add(0,0,1,0, 0,0,3'(w),1,0,0,16'd0);
        // flush coincident with the final accept suppresses done pulses
        add(0,1,1,1, 0,0,3'd0,0,0,0,16'd0);
        add(0,0,0,0, 0,0,3'd0,0,0,0,16'd0);
        // one clean block, then idle 10 cycles
        add(0,1,0,0, 1,1,3'd0,0,0,0,16'd0);
        for (int w = 1; w <= 4; w++) add(0,0,1,0, 0,0,3'(w),1,0,0,16'd0);
        add(0,0,1,0, 0,0,3'd0,0,1,0,16'd1);
        for (int i = 0; i < 10; i++) add(0,0,0,0, 0,0,3'd0,0,0,0,16'd1);
        add(0,1,0,0, 1,1,3'd0,0,0,0,16'd1);
        add(0,0,1,0, 0,0,3'd1,1,0,0,16'd1);
        add(0,0,1,0, 0,0,3'd2,1,0,0,16'd1);
        // reset with flush and conv_ready mid-window
        add(1,1,1,1, 0,0,3'd0,0,0,0,16'd0);
        add(0,0,0,0, 0,0,3'd0,0,0,0,16'd0);

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            drive(v.rst, v.bv, v.cr, v.fl);
            total++;
            if ({ack0, le0, sel0, cv0, bd0, fd0, cnt0} !==
                {v.ack, v.le, v.sel, v.cv, v.bd, v.fd, v.cnt}) begin
                bad++;
                $display("FAIL vec%0d bpf4: got ack=%b le=%b sel=%0d cv=%b bd=%b fd=%b cnt=%0d want ack=%b le=%b sel=%0d cv=%b bd=%b fd=%b cnt=%0d",
                         i, ack0, le0, sel0, cv0, bd0, fd0, cnt0,
                         v.ack, v.le, v.sel, v.cv, v.bd, v.fd, v.cnt);
            end
            total++;
            if ({ack1, le1, sel1, cv1, bd1, fd1, cnt1} !==
                {v.ack, v.le, v.sel, v.cv, v.bd, v.bd, 16'd0}) begin
                bad++;
                $display("FAIL vec%0d bpf1: got ack=%b le=%b sel=%0d cv=%b bd=%b fd=%b cnt=%0d want ack=%b le=%b sel=%0d cv=%b bd=%b fd=%b cnt=0",
                         i, ack1, le1, sel1, cv1, bd1, fd1, cnt1,
                         v.ack, v.le, v.sel, v.cv, v.bd, v.bd);
            end
        end

        // block period: block_valid and conv_ready held, acks every 5 cycles
        block_valid = 1'b1; conv_ready = 1'b1;
        for (int c = 1; c <= 60 && acks.size() < 4; c++) begin
            @(posedge clk);
            #1;
            if (ack0) acks.push_back(c);
            total++;
            if (sel0 > 3'd4 || (cv0 && sel0 == 3'd0)) begin
                bad++;
                $display("FAIL sel_range cycle%0d: got sel=%0d cv=%b want sel 1..4 when valid", c, sel0, cv0);
            end
        end
        total++;
        if (acks.size() < 4) begin
            bad++;
            $display("FAIL ack_timeout: got %0d acks want 4 within 60 cycles", acks.size());
        end else begin
            if (acks[0] != 1) begin
                bad++;
                $display("FAIL first_load: got cycle %0d want cycle 1", acks[0]);
            end
            for (int k = 1; k < 4; k++) begin
                total++;
                if (acks[k] - acks[k-1] != 5) begin
                    bad++;
                    $display("FAIL ack_period%0d: got %0d want 5", k, acks[k] - acks[k-1]);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
